// File: rtl/mac_ctrl_if.sv
// rtl/mac_ctrl_if.sv - handshake and control bundle between the MAC sequencer and its datapath

interface mac_ctrl_if #(
    parameter int n = 6
);
    logic         start_i;
    logic         abort_i;
    logic [n-1:0] n_i;
    logic         z_i;
    logic [1:0]   opc_o;
    logic [1:0]   acc_opc_o;
    logic         rd_o;
    logic         busy_o;
    logic         done_o;

    // Requester / datapath side: drives requests and the index-counter flag
    modport master (
        output start_i,
        output abort_i,
        output n_i,
        output z_i,
        input  opc_o,
        input  acc_opc_o,
        input  rd_o,
        input  busy_o,
        input  done_o
    );

    // Sequencer side
    modport slave (
        input  start_i,
        input  abort_i,
        input  n_i,
        input  z_i,
        output opc_o,
        output acc_opc_o,
        output rd_o,
        output busy_o,
        output done_o
    );
endinterface

// File: rtl/mac_ctrl.sv
// rtl/mac_ctrl.sv - Moore sequencer driving the index counter and accumulator of a MAC datapath

module mac_ctrl #(
    parameter int n = 6
) (
    input  logic       clk_i,
    input  logic       rst_i,
    mac_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_MAC  = 3'd2,
        S_DONE = 3'd3,
        S_CLR  = 3'd4
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic         zf_q;
    logic         zf_d;
    logic [n-1:0] n_s;

    assign n_s = bus.n_i;

    // State and zero-count flag registers; reset is asynchronous so outputs go idle at once
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            zf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            zf_q    <= zf_d;
        end
    end

    // Next-state logic; abort outranks both completion conditions
    always_comb begin
        state_d = state_q;
        zf_d    = zf_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    state_d = S_LOAD;
                    zf_d    = (n_s == '0);
                end
            end
            S_LOAD: begin
                if (bus.abort_i)   state_d = S_CLR;
                else if (zf_q)     state_d = S_DONE;
                else               state_d = S_MAC;
            end
            S_MAC: begin
                if (bus.abort_i)   state_d = S_CLR;
                else if (bus.z_i)  state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            S_CLR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the state register only; unused codes show idle values
    always_comb begin
        bus.opc_o     = 2'd1;
        bus.acc_opc_o = 2'd1;
        bus.rd_o      = 1'b0;
        bus.busy_o    = 1'b0;
        bus.done_o    = 1'b0;
        case (state_q)
            S_LOAD: begin
                bus.opc_o     = 2'd3;
                bus.acc_opc_o = 2'd0;
                bus.busy_o    = 1'b1;
            end
            S_MAC: begin
                bus.opc_o     = 2'd2;
                bus.acc_opc_o = 2'd2;
                bus.rd_o      = 1'b1;
                bus.busy_o    = 1'b1;
            end
            S_DONE: begin
                bus.busy_o    = 1'b1;
                bus.done_o    = 1'b1;
            end
            S_CLR: begin
                bus.opc_o     = 2'd0;
                bus.busy_o    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mac_ctrl.sv
// tb/tb_mac_ctrl.sv - randomized self-checking bench for mac_ctrl against a run-plan reference model

module tb_mac_ctrl;

    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_MAC  = 2;
    localparam int P_DONE = 3;
    localparam int P_CLR  = 4;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    mac_ctrl_if #(.n(6)) bus ();

    mac_ctrl #(.n(6)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    // External index counter, obeying the opcodes the sequencer issues
    int       cnt;
    int       run_n;
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt <= 0;
        else begin
            case (bus.opc_o)
                2'd0: cnt <= 0;
                2'd2: cnt <= cnt - 1;
                2'd3: cnt <= run_n;
                default: ;
            endcase
        end
    end
    assign bus.z_i = (cnt == 1);

    int n_cmp = 0;
    int n_err = 0;
    int cnt_rd, cnt_acc0, cnt_done, cnt_busy;
    int plan[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output vector {opc, acc_opc, rd, busy, done} for each phase of a run
    function automatic logic [6:0] exp_of(input int p);
        case (p)
            P_LOAD:  return {2'd3, 2'd0, 1'b0, 1'b1, 1'b0};
            P_MAC:   return {2'd2, 2'd2, 1'b1, 1'b1, 1'b0};
            P_DONE:  return {2'd1, 2'd1, 1'b0, 1'b1, 1'b1};
            P_CLR:   return {2'd0, 2'd1, 1'b0, 1'b1, 1'b0};
            default: return {2'd1, 2'd1, 1'b0, 1'b0, 1'b0};
        endcase
    endfunction

    function automatic logic [6:0] outs();
        return {bus.opc_o, bus.acc_opc_o, bus.rd_o, bus.busy_o, bus.done_o};
    endfunction

    task automatic clear_counts();
        cnt_rd = 0; cnt_acc0 = 0; cnt_done = 0; cnt_busy = 0;
    endtask

    // One cycle: check this cycle's outputs, apply inputs, advance the plan
    task automatic step(input logic s, input logic a, input logic [5:0] nv);
        int cur;
        cur = (plan.size() > 0) ? plan[0] : P_IDLE;
        check("outs", 32'(outs()), 32'(exp_of(cur)));
        if (bus.rd_o) cnt_rd++;
        if (bus.acc_opc_o == 2'd0) cnt_acc0++;
        if (bus.done_o) cnt_done++;
        if (bus.busy_o) cnt_busy++;
        bus.start_i = s;
        bus.abort_i = a;
        bus.n_i     = nv;
        if (plan.size() > 0) void'(plan.pop_front());
        if (cur == P_IDLE && s) begin
            plan.delete();
            plan.push_back(P_LOAD);
            for (int i = 0; i < int'(nv); i++) plan.push_back(P_MAC);
            plan.push_back(P_DONE);
            run_n = int'(nv);
        end else if ((cur == P_LOAD || cur == P_MAC) && a) begin
            plan.delete();
            plan.push_back(P_CLR);
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        bus.n_i     = '0;
        run_n       = 0;
        repeat (2) @(negedge clk_i);
        check("reset_outs", 32'(outs()), 32'(exp_of(P_IDLE)));
        rst_i = 1'b0;
        @(negedge clk_i);

        // N=3 nominal run
        clear_counts();
        step(1'b1, 1'b0, 6'd3);
        repeat (6) step(1'b0, 1'b0, 6'd0);
        check("n3_done", cnt_done, 1);
        check("n3_rd", cnt_rd, 3);
        check("n3_busy", cnt_busy, 5);

        // N=1: single MAC cycle
        clear_counts();
        step(1'b1, 1'b0, 6'd1);
        repeat (4) step(1'b0, 1'b0, 6'd0);
        check("n1_rd", cnt_rd, 1);
        check("n1_done", cnt_done, 1);

        // N=0: LOAD then DONE, no reads
        clear_counts();
        step(1'b1, 1'b0, 6'd0);
        repeat (3) step(1'b0, 1'b0, 6'd0);
        check("n0_rd", cnt_rd, 0);
        check("n0_acc0", cnt_acc0, 1);
        check("n0_done", cnt_done, 1);

        // Abort in 2nd MAC cycle of N=5
        clear_counts();
        step(1'b1, 1'b0, 6'd5);
        step(1'b0, 1'b0, 6'd0);
        step(1'b0, 1'b0, 6'd0);
        step(1'b0, 1'b1, 6'd0);
        repeat (3) step(1'b0, 1'b0, 6'd0);
        check("abort_done", cnt_done, 0);
        check("abort_rd", cnt_rd, 2);

        // Start held high with N=2: one run every five cycles
        clear_counts();
        repeat (20) step(1'b1, 1'b0, 6'd2);
        step(1'b0, 1'b0, 6'd0);
        check("held_done", cnt_done, 4);
        check("held_rd", cnt_rd, 8);

        // Asynchronous reset mid-MAC
        step(1'b1, 1'b0, 6'd5);
        step(1'b0, 1'b0, 6'd0);
        step(1'b0, 1'b0, 6'd0);
        check("pre_rst_mac", 32'(outs()), 32'(exp_of(P_MAC)));
        #2 rst_i = 1'b1;
        #1 check("async_rst_outs", 32'(outs()), 32'(exp_of(P_IDLE)));
        plan.delete();
        @(negedge clk_i);
        check("rst_hold_outs", 32'(outs()), 32'(exp_of(P_IDLE)));
        rst_i = 1'b0;
        clear_counts();
        step(1'b1, 1'b0, 6'd4);
        repeat (7) step(1'b0, 1'b0, 6'd0);
        check("post_rst_done", cnt_done, 1);
        check("post_rst_rd", cnt_rd, 4);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            step(($urandom % 4) == 0, ($urandom % 10) == 0, 6'($urandom_range(0, 11)));
        end
        repeat (15) step(1'b0, 1'b0, 6'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mac_ctrl.md
MAC_CTRL -- requirements
Module: mac_ctrl

Interface
REQ-001 The block SHALL have parameter n, default 6, giving the width of the element-count input n_i.
REQ-002 clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  asynchronous, active-high reset.
REQ-004 start_i  input  1  request to start one MAC run; sampled in IDLE only.
REQ-005 abort_i  input  1  request to cancel the run in progress.
REQ-006 n_i  input  n  element count for the run; sampled in the cycle start_i is accepted.
REQ-007 z_i  input  1  count-is-one flag from the index counter (high when index == 1).
REQ-008 opc_o  output  2  index-counter opcode: 0 clear, 1 hold, 2 decrement, 3 load n_i.
REQ-009 acc_opc_o  output  2  accumulator opcode: 0 clear, 1 hold, 2 accumulate product, 3 reserved (never driven).
REQ-010 rd_o  output  1  operand-memory read strobe, high while an element is consumed.
REQ-011 busy_o  output  1  high in every state except IDLE.
REQ-012 done_o  output  1  one-cycle pulse marking completion of a run.

Function
REQ-013 The block SHALL be a Moore FSM with the states IDLE, LOAD, MAC, DONE and CLR; all outputs SHALL decode from the state register only.
REQ-014 The IDLE outputs SHALL be opc_o=1, acc_opc_o=1, rd_o=0, busy_o=0, done_o=0.
REQ-015 In IDLE with start_i=1 the block SHALL go to LOAD and register zf_q = (n_i == 0); with start_i=0 it SHALL stay in IDLE.
REQ-016 The LOAD outputs SHALL be opc_o=3, acc_opc_o=0, rd_o=0, busy_o=1, done_o=0.
REQ-017 From LOAD the block SHALL go to DONE if zf_q=1, otherwise to MAC.
REQ-018 The MAC outputs SHALL be opc_o=2, acc_opc_o=2, rd_o=1, busy_o=1, done_o=0.
REQ-019 In MAC the block SHALL go to DONE when z_i=1 and SHALL stay in MAC when z_i=0, so that a run with count N (N>=1) spends exactly N cycles in MAC.
REQ-020 The DONE outputs SHALL be opc_o=1, acc_opc_o=1, rd_o=0, busy_o=1, done_o=1; DONE SHALL always go to IDLE after one cycle.
REQ-021 The CLR outputs SHALL be opc_o=0, acc_opc_o=1, rd_o=0, busy_o=1, done_o=0; CLR SHALL always go to IDLE after one cycle.
REQ-022 An abort_i=1 sampled in LOAD or MAC SHALL move the block to CLR, with priority over z_i and zf_q; abort_i SHALL be ignored in IDLE, DONE and CLR.
REQ-023 start_i SHALL be ignored in every state other than IDLE; at least one IDLE cycle SHALL separate runs, so a start_i held high restarts in the cycle after the return to IDLE.
REQ-024 Latency: with start_i accepted at edge 0, LOAD SHALL be at cycle 1, MAC at cycles 2..N+1, and done_o SHALL be high at cycle N+2 (N=0: done_o high at cycle 2).
REQ-025 Unused state encodings SHALL recover to IDLE on the next clock edge.

Reset
REQ-026 rst_i=1 SHALL force the state to IDLE and zf_q to 0 immediately, regardless of clk_i.
REQ-027 While rst_i is high, all outputs SHALL show the IDLE values of REQ-014.
REQ-028 A reset during any state SHALL abandon the run with no done_o pulse.

Verification
REQ-029 n_i=3 with a model counter, start pulse -> LOAD 1 cycle (opc 3, acc 0); MAC 3 cycles (opc 2, acc 2, rd 1), z_i high in the 3rd; done_o high at cycle 5; busy_o high at cycles 1-5.
REQ-030 n_i=1 -> exactly one MAC cycle with z_i=1; done_o at cycle 3.
REQ-031 n_i=0 -> LOAD then DONE; rd_o never high; acc_opc_o=0 seen exactly once.
REQ-032 abort_i in the 2nd MAC cycle of an n_i=5 run -> CLR next cycle (opc 0), then IDLE; done_o stays 0.
REQ-033 start_i held high continuously with n_i=2 -> runs repeat with exactly one IDLE cycle between each done_o pulse and the next LOAD.
REQ-034 rst_i asserted mid-MAC between clock edges -> outputs take the IDLE values without waiting for a clock edge; a later start runs normally.
